bht_controller: RTL
===================

// Module: bht_controller
// PURPOSE
//  Branch history table (BHT) controller. Holds 2**INDEX_W two-bit saturating predictor counters.
//  Serves one lookup and one update per cycle, and sequences table initialisation after reset or flush.
//  Sits between fetch (lookup) and execute (resolved-branch update) in the pipeline.
// PARAMETERS
//  INDEX_W     4      table index width; the table holds 2**INDEX_W entries
//  INIT_STATE  2'd1   value written to every entry during init (01 = weakly not-taken)
// PORTS
//  i_clock         in   1        single clock; all logic on posedge
//  i_init_n        in   1        synchronous, active-low reset
//  i_flush         in   1        request table re-initialisation
//  i_lookup_valid  in   1        lookup request; accepted only when o_busy==0
//  i_lookup_index  in   INDEX_W  entry to read
//  i_upd_valid     in   1        resolved-branch update; accepted only when o_busy==0
//  i_upd_index     in   INDEX_W  entry to update
//  i_upd_taken     in   1        resolved branch outcome (1 = taken)
//  o_busy          out  1        init sequence in progress; lookups and updates are ignored
//  o_pred_valid    out  1        1-cycle pulse; the prediction fields below are valid
//  o_pred_taken    out  1        predicted direction; equals the MSB of the counter
//  o_pred_state    out  2        counter value returned by the lookup
//  o_upd_count     out  16       accepted updates      (BHT_STATS_EN only)
//  o_mispred_count out  16       mispredicted updates  (BHT_STATS_EN only)
// BEHAVIOUR
//  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  - Update rule: taken -> +1, saturating at 11. Not-taken -> -1, saturating at 00.
//  - FSM states: INIT, RUN.
//    - i_init_n==0 at posedge -> INIT; the clear index is set to 0.
//    - INIT writes INIT_STATE to entry[clear index], then increments the index, one entry per cycle.
//    - INIT lasts exactly 2**INDEX_W cycles. After the last index, the FSM moves to RUN.
//    - In RUN, i_flush==1 -> INIT with the clear index set to 0.
//    - i_flush in INIT restarts the sequence from index 0.
//  - Reset values:
//    - o_busy=1.
//    - o_pred_valid=0, o_pred_taken=0, o_pred_state=0.
//    - Stats counters = 0.
//    - Table contents are undefined until INIT completes.
//  - o_busy is 1 in INIT and 0 in RUN, and is registered.
//    - o_busy falls in the cycle after the last entry is written.
//  - Lookup latency is 1 cycle.
//    - A lookup accepted at edge N gives o_pred_valid=1 after edge N+1 for one cycle.
//    - Every accepted lookup gets a response: a lookup every cycle gives o_pred_valid held high.
//    - A lookup while o_busy==1 produces no o_pred_valid.
//  - Update:
//    - Accepted at the edge; the new counter value is visible to lookups from the next cycle.
//    - Updates while o_busy==1 are dropped.
//  - Collision: a lookup and an update to the same index in the same cycle return the post-update value.
//  - Back-to-back updates to one index accumulate, with no lost increments.
//  - Flush and update in the same RUN cycle: the flush wins and the update is dropped.
//  - Reset mid-init or mid-run: immediate return to the reset values; any pending o_pred_valid is cancelled.
// CONFIGURATION
//  BHT_STATS_EN defined:
//  - o_upd_count increments on each accepted update.
//  - o_mispred_count increments when the pre-update counter MSB != i_upd_taken.
//  - Both counters saturate at 16'hFFFF.
//  - Both clear on reset only; i_flush does not clear them.
//  BHT_STATS_EN undefined: both outputs are tied to 16'd0 and no stats registers exist.
// TESTING
//  1. Release reset -> o_busy=1 for exactly 16 cycles (INDEX_W=4) then 0.
//     Then lookup of idx 5 -> o_pred_state=2'd1, o_pred_taken=0.
//  2. 4 taken updates to idx 3 -> state 1->2->3->3 (saturation).
//     Then lookup -> o_pred_state=3, o_pred_taken=1.
//  3. Alternating T/NT updates to idx 7, starting from 1 -> states 2,1,2,1.
//     Lookup after each update matches.
//  4. Same-cycle lookup and taken update on idx 9 (state 1) -> response o_pred_state=2.
//  5. i_flush in RUN at cycle 40 -> o_busy=1 for 16 cycles.
//     Lookups and updates issued during that window are ignored.
//     Afterwards all entries read 1.
//  6. With BHT_STATS_EN: 4 updates to idx 2 (T,T,NT,T) starting from state 1 ->
//     o_upd_count=4 and o_mispred_count=2 (updates 1 and 3 mispredicted).

Source files
------------

// File: rtl/bht_controller.sv
// ---------------------------------------------------------------------------
// bht_controller
//
// Branch history table controller. Holds 2**INDEX_W two-bit saturating
// predictor counters. Each cycle it serves one lookup from fetch and one
// resolved-branch update from execute. It also runs the table
// initialisation sequence after reset or flush.
//
// Counter encoding:
//   00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
//   The predicted direction is the counter MSB.
//
// Parameters:
//   INDEX_W     table index width; the table holds 2**INDEX_W entries
//   INIT_STATE  value written to every entry during initialisation
//
// Ports:
//   i_clock          single clock; all logic on posedge
//   i_init_n         synchronous active-low reset
//   i_flush          request table re-initialisation
//   i_lookup_valid   lookup request (ignored while o_busy)
//   i_lookup_index   entry to read
//   i_upd_valid      resolved-branch update (ignored while o_busy)
//   i_upd_index      entry to update
//   i_upd_taken      resolved outcome, 1 = taken
//   o_busy           initialisation in progress
//   o_pred_valid     one-cycle pulse; the prediction fields are valid
//   o_pred_taken     predicted direction (counter MSB)
//   o_pred_state     counter value returned by the lookup
//   o_upd_count      accepted updates (statistics build only, else 0)
//   o_mispred_count  mispredicted updates (statistics build only, else 0)
//
// Configuration macro:
//   BHT_STATS_EN  when defined, saturating 16-bit update and misprediction
//                 counters are built. They clear on reset only. When the
//                 macro is undefined, both outputs are tied to zero.
//
// Timing:
//   A lookup sampled at edge N reads the table during the following cycle.
//   The response is registered at edge N+1. An update sampled at the same
//   edge N is therefore already in the table when the read happens, so a
//   same-index collision returns the post-update value without a bypass.
// ---------------------------------------------------------------------------
module bht_controller #(
  parameter int unsigned INDEX_W    = 4,
  parameter logic [1:0]  INIT_STATE = 2'd1
) (
  input  logic               i_clock,
  input  logic               i_init_n,
  input  logic               i_flush,
  input  logic               i_lookup_valid,
  input  logic [INDEX_W-1:0] i_lookup_index,
  input  logic               i_upd_valid,
  input  logic [INDEX_W-1:0] i_upd_index,
  input  logic               i_upd_taken,
  output logic               o_busy,
  output logic               o_pred_valid,
  output logic               o_pred_taken,
  output logic [1:0]         o_pred_state,
  output logic [15:0]        o_upd_count,
  output logic [15:0]        o_mispred_count
);

  localparam int unsigned        DEPTH    = 2 ** INDEX_W;
  localparam logic [INDEX_W-1:0] IDX_ZERO = {INDEX_W{1'b0}};
  localparam logic [INDEX_W-1:0] IDX_ONE  = INDEX_W'(1);
  localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Two-bit saturating counter step.
  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (cnt == 2'b11) begin
        res = 2'b11;
      end else begin
        res = cnt + 2'b01;
      end
    end else begin
      if (cnt == 2'b00) begin
        res = 2'b00;
      end else begin
        res = cnt - 2'b01;
      end
    end
    return res;
  endfunction

  // Predictor storage. Contents are undefined until the first init completes.
  logic [1:0]         table_r [DEPTH];

  // FSM and sequencing state.
  state_t             state_r;
  state_t             state_nxt_s;
  logic [INDEX_W-1:0] clear_idx_r;
  logic [INDEX_W-1:0] clear_nxt_s;
  logic               init_wr_s;
  logic               busy_r;

  // Lookup pipeline: request stage, then response stage.
  logic               lkp_vld_r;
  logic [INDEX_W-1:0] lkp_idx_r;
  logic               pred_valid_r;
  logic [1:0]         pred_state_r;

  // Request acceptance and update datapath.
  logic               lkp_acc_s;
  logic               upd_acc_s;
  logic [1:0]         upd_old_s;
  logic [1:0]         upd_new_s;

  // Next-state logic for the init/run sequencer.
  always_comb begin
    state_nxt_s = state_r;
    clear_nxt_s = clear_idx_r;
    init_wr_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (i_flush) begin
          // A flush during init restarts the sweep without writing this cycle.
          state_nxt_s = ST_INIT;
          clear_nxt_s = IDX_ZERO;
        end else begin
          init_wr_s = 1'b1;
          if (clear_idx_r == LAST_IDX) begin
            state_nxt_s = ST_RUN;
            clear_nxt_s = IDX_ZERO;
          end else begin
            state_nxt_s = ST_INIT;
            clear_nxt_s = clear_idx_r + IDX_ONE;
          end
        end
      end
      ST_RUN: begin
        if (i_flush) begin
          state_nxt_s = ST_INIT;
          clear_nxt_s = IDX_ZERO;
        end else begin
          state_nxt_s = ST_RUN;
          clear_nxt_s = clear_idx_r;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        clear_nxt_s = IDX_ZERO;
      end
    endcase
  end

  // Acceptance: only in RUN. A flush in the same cycle drops the update.
  always_comb begin
    lkp_acc_s = 1'b0;
    upd_acc_s = 1'b0;
    if (state_r == ST_RUN) begin
      lkp_acc_s = i_lookup_valid;
      upd_acc_s = i_upd_valid & ~i_flush;
    end else begin
      lkp_acc_s = 1'b0;
      upd_acc_s = 1'b0;
    end
  end

  // Read-modify-write value for the update port.
  always_comb begin
    upd_old_s = table_r[i_upd_index];
    upd_new_s = sat_next(upd_old_s, i_upd_taken);
  end

  // Table write port: the init sweep and updates never overlap.
  always_ff @(posedge i_clock) begin
    if (i_init_n) begin
      if (init_wr_s) begin
        table_r[clear_idx_r] <= INIT_STATE;
      end else if (upd_acc_s) begin
        table_r[i_upd_index] <= upd_new_s;
      end
    end
  end

  // Sequencer state, busy flag and lookup pipeline registers.
  always_ff @(posedge i_clock) begin
    if (!i_init_n) begin
      state_r      <= ST_INIT;
      clear_idx_r  <= IDX_ZERO;
      busy_r       <= 1'b1;
      lkp_vld_r    <= 1'b0;
      lkp_idx_r    <= IDX_ZERO;
      pred_valid_r <= 1'b0;
      pred_state_r <= 2'd0;
    end else begin
      state_r      <= state_nxt_s;
      clear_idx_r  <= clear_nxt_s;
      busy_r       <= (state_nxt_s == ST_INIT);
      lkp_vld_r    <= lkp_acc_s;
      if (lkp_acc_s) begin
        lkp_idx_r <= i_lookup_index;
      end
      pred_valid_r <= lkp_vld_r;
      if (lkp_vld_r) begin
        pred_state_r <= table_r[lkp_idx_r];
      end
    end
  end

  assign o_busy       = busy_r;
  assign o_pred_valid = pred_valid_r;
  assign o_pred_state = pred_state_r;
  assign o_pred_taken = pred_state_r[1];

`ifdef BHT_STATS_EN
  logic [15:0] upd_cnt_r;
  logic [15:0] mis_cnt_r;
  logic        mispred_s;

  // The prediction that was in force is the MSB of the pre-update counter.
  assign mispred_s = (upd_old_s[1] != i_upd_taken);

  // Saturating statistics counters; a flush leaves them untouched.
  always_ff @(posedge i_clock) begin
    if (!i_init_n) begin
      upd_cnt_r <= 16'd0;
      mis_cnt_r <= 16'd0;
    end else if (upd_acc_s) begin
      if (upd_cnt_r != 16'hFFFF) begin
        upd_cnt_r <= upd_cnt_r + 16'd1;
      end
      if (mispred_s && (mis_cnt_r != 16'hFFFF)) begin
        mis_cnt_r <= mis_cnt_r + 16'd1;
      end
    end
  end

  assign o_upd_count     = upd_cnt_r;
  assign o_mispred_count = mis_cnt_r;
`else
  assign o_upd_count     = 16'd0;
  assign o_mispred_count = 16'd0;
`endif

endmodule
